// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the ADC ramp generator and the column-latch decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int GRAY_W = 8;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down; inverse of bin2gray.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray_enc.sv
// Width-parameterised combinational binary-to-Gray encoder.
module bin_to_gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_ramp_counter.sv
// Gray-coded ramp counter for the ADC column latches; start/stop/load controlled, done on terminal count.
// Optional macro GRAY_RAMP_CHECK_EN adds a sticky gray_err output that monitors the Gray bus.
module gray_ramp_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_W,
  parameter int MAX_COUNT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] bin_value,
  output logic [WIDTH-1:0] gray_value,
  output logic             busy,
  output logic             done
`ifdef GRAY_RAMP_CHECK_EN
  , output logic           gray_err
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_done;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_done_next;
  logic             w_start;

  // stop outranks start whenever both are sampled together
  assign w_start = start & ~stop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (r_state == HOLD && stop) begin
          w_state_next = IDLE;
        end else if (w_start) begin
          if (load) begin
            w_bin_next   = load_value;
            w_state_next = RUN;
          end else if (r_bin == MAX_V) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_state_next = RUN;
          end
        end else if (load) begin
          w_bin_next = load_value;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_next = HOLD;
        end else if (r_bin >= MAX_V) begin
          // Preloaded at or beyond the terminal count: finish without counting.
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_bin_next = r_bin + 1'b1;
          if (w_bin_next == MAX_V) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
  end

  // Gray is encoded from the next binary value so both registers always agree.
  bin_to_gray_enc #(.WIDTH(WIDTH)) u_enc (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_done <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_done <= w_done_next;
    end
  end

  assign bin_value  = r_bin;
  assign gray_value = r_gray;
  assign done       = r_done;

`ifdef GRAY_RAMP_CHECK_EN
  logic [WIDTH-1:0] r_gray_prev;
  logic             r_run_prev;
  logic             r_gray_err;
  logic [WIDTH-1:0] w_gray_ref;
  logic             w_step_bad;

  bin_to_gray_enc #(.WIDTH(WIDTH)) u_ref_enc (
    .i_bin  (r_bin),
    .o_gray (w_gray_ref)
  );

  // RUN in both the previous and current cycle means the edge between them was an increment.
  assign w_step_bad = r_run_prev && (r_state == RUN) && ($countones(r_gray ^ r_gray_prev) != 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gray_prev <= '0;
      r_run_prev  <= 1'b0;
      r_gray_err  <= 1'b0;
    end else begin
      r_gray_prev <= r_gray;
      r_run_prev  <= (r_state == RUN);
      if (w_step_bad || (r_gray != w_gray_ref)) r_gray_err <= 1'b1;
    end
  end

  assign gray_err = r_gray_err;
`endif

endmodule

// File: tb/tb_gray_ramp_counter.sv
// Self-checking bench for gray_ramp_counter: per-cycle behavioural model plus directed literal checks.
module tb_gray_ramp_counter;

  localparam int W   = 8;
  localparam int MAX = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] bin_value;
  logic [W-1:0] gray_value;
  logic         busy;
  logic         done;
`ifdef GRAY_RAMP_CHECK_EN
  logic         gray_err;
`endif

  gray_ramp_counter #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .bin_value  (bin_value),
    .gray_value (gray_value),
    .busy       (busy),
    .done       (done)
`ifdef GRAY_RAMP_CHECK_EN
    , .gray_err (gray_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_bin(input int v, input int limit);
    for (int i = 0; i < limit && bin_value !== v[W-1:0]; i++) @(negedge clk);
    n_tests++;
    if (bin_value !== v[W-1:0]) begin
      n_fail++;
      $display("FAIL wait_bin: got 0x%0h, expected 0x%0h within %0d cycles", bin_value, v, limit);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: got done=%b, expected 1 within %0d cycles", done, limit);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Model: m_state 0 = idle, 1 = running, 2 = held; count kept as a plain integer.
  int m_state = 0;
  int m_bin   = 0;
  bit m_done  = 1'b0;

  always @(posedge clk) begin : model
    int s;
    int b;
    bit d;
    s = m_state;
    b = m_bin;
    d = 1'b0;
    if (reset) begin
      s = 0;
      b = 0;
    end else if (s == 1) begin
      if (stop) s = 2;
      else if (b >= MAX) begin
        d = 1'b1;
        s = 0;
      end else begin
        b = b + 1;
        if (b == MAX) begin
          d = 1'b1;
          s = 0;
        end
      end
    end else if (s == 2 && stop) begin
      s = 0;
    end else if (start && !stop) begin
      if (load) begin
        b = int'(load_value);
        s = 1;
      end else if (b == MAX) d = 1'b1;
      else s = 1;
    end else if (load) begin
      b = int'(load_value);
    end
    m_state <= s;
    m_bin   <= b;
    m_done  <= d;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_bin", bin_value, m_bin);
      check("model_gray", gray_value, m_bin ^ (m_bin >> 1));
      check("model_busy", busy, m_state == 1);
      check("model_done", done, m_done);
`ifdef GRAY_RAMP_CHECK_EN
      check("model_gray_err", gray_err, 0);
`endif
    end
  end

  logic [W-1:0] ramp_g [6];
  logic [W-1:0] g_prev;

  initial begin
    ramp_g = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
    reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_value = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("reset_bin", bin_value, 0);
    check("reset_gray", gray_value, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // First six RUN cycles from zero
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check("ramp_gray", gray_value, ramp_g[k]);
      check("ramp_busy", busy, 1);
    end

    // Run to terminal count
    wait_done(300);
    check("term_bin", bin_value, 255);
    check("term_gray", gray_value, 8'h80);
    check("term_busy", busy, 0);
    @(negedge clk);
    check("term_done_drop", done, 0);
    check("term_hold_bin", bin_value, 255);
    check("term_hold_gray", gray_value, 8'h80);

    // Start while already at MAX: done pulse, no RUN
    pulse_start();
    check("startmax_done", done, 1);
    check("startmax_busy", busy, 0);
    @(negedge clk);
    check("startmax_done_drop", done, 0);

    // Preload 127 and cross the MSB boundary
    load = 1'b1; load_value = 8'd127;
    @(negedge clk);
    load = 1'b0;
    check("load127_bin", bin_value, 127);
    check("load127_gray", gray_value, 8'h40);
    pulse_start();
    check("load127_busy", busy, 1);
    g_prev = gray_value;
    @(negedge clk);
    check("cross_bin", bin_value, 128);
    check("cross_gray", gray_value, 8'hC0);
    check("cross_onebit", $countones(gray_value ^ g_prev), 1);
    pulse_stop();
    check("hold_busy", busy, 0);
    check("hold_bin", bin_value, 128);
    pulse_stop();
    check("abort_busy", busy, 0);
    check("abort_bin", bin_value, 128);

    // Pause at 10, hold, resume
    load = 1'b1; load_value = 8'd0;
    @(negedge clk);
    load = 1'b0;
    pulse_start();
    wait_bin(10, 50);
    pulse_stop();
    check("pause_bin", bin_value, 10);
    check("pause_gray", gray_value, 8'h0F);
    check("pause_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("pause_keep_gray", gray_value, 8'h0F);
    pulse_start();
    check("resume_busy", busy, 1);
    check("resume_bin", bin_value, 10);
    @(negedge clk);
    check("resume_next_bin", bin_value, 11);
    check("resume_next_gray", gray_value, 8'h0E);

    // start && stop in RUN: stop wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("both_busy", busy, 0);
    check("both_bin", bin_value, 11);
    pulse_start();

    // Load during RUN is ignored
    load = 1'b1; load_value = 8'd200;
    @(negedge clk);
    load = 1'b0;
    check("runload_bin", bin_value, 12);
    @(negedge clk);
    check("runload_next_bin", bin_value, 13);

    // Reset mid-ramp
    wait_bin(50, 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_bin", bin_value, 0);
    check("midreset_gray", gray_value, 0);
    check("midreset_busy", busy, 0);

    // load && start together, short ramp to MAX
    load = 1'b1; start = 1'b1; load_value = 8'd253;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("ldstart_bin", bin_value, 253);
    check("ldstart_busy", busy, 1);
    @(negedge clk);
    check("ldstart_inc", bin_value, 254);
    @(negedge clk);
    check("ldstart_done", done, 1);
    check("ldstart_end_bin", bin_value, 255);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
    $fatal(1);
  end

endmodule
